// File: rtl/fifo_fill_pkg.sv
// rtl/fifo_fill_pkg.sv - register offsets, FSM states and STATUS layout for fifo_fill_ctrl
package fifo_fill_pkg;

  localparam logic [15:0] OFF_DATA   = 16'd0;
  localparam logic [15:0] OFF_SEED   = 16'd2;
  localparam logic [15:0] OFF_CMD    = 16'd4;
  localparam logic [15:0] OFF_STATUS = 16'd6;
  localparam logic [15:0] OFF_CTRL   = 16'd8;
  localparam logic [15:0] OFF_CSUM   = 16'd10;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } t_fill_state;

  localparam int ST_BUSY     = 0;
  localparam int ST_PRIMED   = 1;
  localparam int ST_FILL_LSB = 16;
  localparam int ST_DROP_LSB = 48;
  localparam int ST_FIELD_W  = 16;

  localparam int CTRL_ABORT = 0;
  localparam int CTRL_CLEAR = 1;

endpackage

// File: rtl/fifo_fill_engine.sv
// rtl/fifo_fill_engine.sv - burst fill FSM: shifts count words seed+i, one per cycle
module fill_engine
  import fifo_fill_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] count,
  input  logic [63:0]      seed,
  output logic             fill_en,
  output logic [63:0]      fill_d,
  output logic             busy
);

  t_fill_state      state;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] last_idx;
  logic [63:0]      base;

  // Outputs are registered so the word for index i appears in the cycle the FSM sits on i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      last_idx <= '0;
      base     <= '0;
      fill_en  <= 1'b0;
      fill_d   <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (count != '0)) begin
            state    <= FILL;
            busy     <= 1'b1;
            fill_en  <= 1'b1;
            fill_d   <= seed;
            base     <= seed;
            idx      <= '0;
            last_idx <= count - CNT_W'(1);
          end
        end
        FILL: begin
          if (abort || (idx == last_idx)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            fill_en <= 1'b0;
          end else begin
            idx    <= idx + CNT_W'(1);
            fill_d <= base + 64'(idx) + 64'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_fill_ctrl.sv
// rtl/fifo_fill_ctrl.sv - MMIO sequencer for the shift-register FIFO; FILL_CHECKSUM_EN adds the XOR checksum at +10
module fifo_fill_ctrl
  import fifo_fill_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0020,
  parameter int          CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mmio_wr_valid,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_addr,
  input  logic [8:0]  mmio_tid,
  input  logic [63:0] mmio_wdata,
  output logic        fifo_en,
  output logic [63:0] fifo_d,
  input  logic [63:0] fifo_q,
  output logic        rd_rsp_valid,
  output logic [8:0]  rd_rsp_tid,
  output logic [63:0] rd_rsp_data,
  output logic        busy
);

  logic [15:0]      off;
  logic             wr_data, wr_seed, wr_cmd, wr_ctrl, rd_req;
  logic             clr, drop;
  logic             push_en;
  logic [63:0]      push_d;
  logic             fill_en;
  logic [63:0]      fill_d;
  logic [63:0]      seed;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] fill_lvl;
  logic [CNT_W-1:0] drop_cnt;
  logic             primed;
  logic             rd_hit;
  logic [63:0]      rd_mux;
  logic [63:0]      status;

  // Addresses below the base wrap to large offsets and miss every register.
  assign off     = mmio_addr - BASE_ADDR;
  assign wr_data = mmio_wr_valid && (off == OFF_DATA);
  assign wr_seed = mmio_wr_valid && (off == OFF_SEED);
  assign wr_cmd  = mmio_wr_valid && (off == OFF_CMD);
  assign wr_ctrl = mmio_wr_valid && (off == OFF_CTRL);
  assign rd_req  = mmio_rd_valid && !mmio_wr_valid;
  assign clr     = wr_ctrl && mmio_wdata[CTRL_CLEAR];
  assign drop    = (wr_data || wr_cmd) && busy;
  assign primed  = (fill_lvl == CNT_W'(DEPTH));

  fill_engine #(.CNT_W(CNT_W)) u_engine (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (wr_cmd && !busy),
    .abort   (wr_ctrl && mmio_wdata[CTRL_ABORT]),
    .count   (mmio_wdata[CNT_W-1:0]),
    .seed    (seed),
    .fill_en (fill_en),
    .fill_d  (fill_d),
    .busy    (busy)
  );

  // Host pushes and bursts never overlap: pushes arriving while busy are dropped.
  assign fifo_en = push_en | fill_en;
  assign fifo_d  = fill_en ? fill_d : push_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_en  <= 1'b0;
      push_d   <= '0;
      seed     <= '0;
      last_cnt <= '0;
    end else begin
      push_en <= wr_data && !busy;
      if (wr_data && !busy) push_d <= mmio_wdata;
      if (wr_seed) seed <= mmio_wdata;
      if (wr_cmd && !busy) last_cnt <= mmio_wdata[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_lvl <= '0;
      drop_cnt <= '0;
    end else if (clr) begin
      fill_lvl <= '0;
      drop_cnt <= '0;
    end else begin
      if (fifo_en && !primed) fill_lvl <= fill_lvl + CNT_W'(1);
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

`ifdef FILL_CHECKSUM_EN
  logic [63:0] csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum <= '0;
    else if (clr) csum <= '0;
    else if (fifo_en) csum <= csum ^ fifo_d;
  end
`endif

  always_comb begin
    status                                = '0;
    status[ST_BUSY]                       = busy;
    status[ST_PRIMED]                     = primed;
    status[ST_FILL_LSB +: ST_FIELD_W]     = ST_FIELD_W'(fill_lvl);
    status[ST_DROP_LSB +: ST_FIELD_W]     = ST_FIELD_W'(drop_cnt);
  end

  always_comb begin
    rd_hit = 1'b0;
    rd_mux = '0;
    case (off)
      OFF_DATA:   begin rd_hit = 1'b1; rd_mux = fifo_q;         end
      OFF_SEED:   begin rd_hit = 1'b1; rd_mux = seed;           end
      OFF_CMD:    begin rd_hit = 1'b1; rd_mux = 64'(last_cnt);  end
      OFF_STATUS: begin rd_hit = 1'b1; rd_mux = status;         end
      OFF_CTRL:   begin rd_hit = 1'b1; rd_mux = '0;             end
`ifdef FILL_CHECKSUM_EN
      OFF_CSUM:   begin rd_hit = 1'b1; rd_mux = csum;           end
`endif
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_tid   <= '0;
      rd_rsp_data  <= '0;
    end else begin
      rd_rsp_valid <= rd_req && rd_hit;
      if (rd_req && rd_hit) begin
        rd_rsp_tid  <= mmio_tid;
        rd_rsp_data <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// tb/tb_fifo_fill_ctrl.sv - self-checking bench for fifo_fill_ctrl
module tb_fifo_fill_ctrl;

  localparam int          DEPTH = 8;
  localparam logic [15:0] BASE  = 16'h0020;
`ifdef FILL_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mmio_wr_valid = 1'b0;
  logic        mmio_rd_valid = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [8:0]  mmio_tid = '0;
  logic [63:0] mmio_wdata = '0;
  logic        fifo_en;
  logic [63:0] fifo_d;
  logic [63:0] fifo_q;
  logic        rd_rsp_valid;
  logic [8:0]  rd_rsp_tid;
  logic [63:0] rd_rsp_data;
  logic        busy;

  always #5 clk = ~clk;

  fifo_fill_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mmio_wr_valid (mmio_wr_valid),
    .mmio_rd_valid (mmio_rd_valid),
    .mmio_addr     (mmio_addr),
    .mmio_tid      (mmio_tid),
    .mmio_wdata    (mmio_wdata),
    .fifo_en       (fifo_en),
    .fifo_d        (fifo_d),
    .fifo_q        (fifo_q),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_tid    (rd_rsp_tid),
    .rd_rsp_data   (rd_rsp_data),
    .busy          (busy)
  );

  // The attached shift-register FIFO; its contents are not reset.
  logic [DEPTH*64-1:0] fpipe = '0;
  always @(posedge clk) if (fifo_en) fpipe <= {fpipe[(DEPTH-1)*64-1:0], fifo_d};
  assign fifo_q = fpipe[DEPTH*64-1 -: 64];

  // Reference model: the shift word expected in each cycle, plus register state.
  logic [63:0] sched [int];
  int          cyc, bstart, bend, clear_cyc, m_drop, busy_cyc;
  logic [63:0] m_seed;
  logic [15:0] m_cnt;
  logic        pend_v;
  logic [8:0]  pend_tid;
  logic [63:0] pend_data;
  logic        rsp_seen;
  logic [63:0] rsp_data;
  logic [63:0] obs [$];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        wr;
    logic [15:0] off;
    logic [63:0] wd;
    logic [8:0]  tid;
    logic        exp_v;
    logic [63:0] exp_d;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic bit m_busy(input int c);
    return (c > bstart) && (c <= bend);
  endfunction

  function automatic int m_fill(input int r);
    int n = 0;
    foreach (sched[k]) if (k > clear_cyc && k < r) n++;
    return (n > DEPTH) ? DEPTH : n;
  endfunction

  function automatic logic [63:0] m_head(input int r);
    logic [63:0] q [$];
    foreach (sched[k]) if (k < r) q.push_back(sched[k]);
    return (q.size() >= DEPTH) ? q[q.size()-DEPTH] : 64'd0;
  endfunction

  function automatic logic [63:0] m_csum(input int r);
    logic [63:0] x = '0;
    foreach (sched[k]) if (k > clear_cyc && k < r) x ^= sched[k];
    return x;
  endfunction

  function automatic logic [63:0] m_status(input int r);
    return {16'(m_drop), 16'h0, 16'(m_fill(r)), 14'h0, (m_fill(r) == DEPTH), m_busy(r)};
  endfunction

  task automatic m_read(input logic [15:0] off, output logic hit, output logic [63:0] d);
    hit = 1'b1;
    d   = '0;
    case (off)
      16'd0:   d = m_head(cyc);
      16'd2:   d = m_seed;
      16'd4:   d = 64'(m_cnt);
      16'd6:   d = m_status(cyc);
      16'd8:   d = '0;
      16'd10:  begin hit = CSUM_ON; d = CSUM_ON ? m_csum(cyc) : 64'd0; end
      default: hit = 1'b0;
    endcase
  endtask

  // One clock: check this cycle's outputs, drive this cycle's inputs, advance the model.
  task automatic step(input logic wr, input logic rd, input logic [15:0] off,
                      input logic [63:0] wd, input logic [8:0] tid);
    logic        hit;
    logic [63:0] rdv;
    chk("fifo_en", fifo_en, sched.exists(cyc));
    if (fifo_en) obs.push_back(fifo_d);
    if (fifo_en && sched.exists(cyc)) chk("fifo_d", fifo_d, sched[cyc]);
    chk("busy", busy, m_busy(cyc));
    if (busy) busy_cyc++;
    chk("rd_rsp_valid", rd_rsp_valid, pend_v);
    rsp_seen = rd_rsp_valid;
    rsp_data = rd_rsp_data;
    if (pend_v && rd_rsp_valid) begin
      chk("rd_rsp_tid", rd_rsp_tid, pend_tid);
      chk("rd_rsp_data", rd_rsp_data, pend_data);
    end
    mmio_wr_valid = wr;
    mmio_rd_valid = rd;
    mmio_addr     = BASE + off;
    mmio_wdata    = wd;
    mmio_tid      = tid;
    pend_v        = 1'b0;
    if (wr) begin
      case (off)
        16'd0: if (m_busy(cyc)) m_drop++; else sched[cyc+1] = wd;
        16'd2: m_seed = wd;
        16'd4: begin
          if (m_busy(cyc)) m_drop++;
          else begin
            m_cnt = wd[15:0];
            if (m_cnt != 0) begin
              bstart = cyc;
              bend   = cyc + int'(m_cnt);
              for (int k = 0; k < int'(m_cnt); k++) sched[cyc+1+k] = m_seed + 64'(k);
            end
          end
        end
        16'd8: begin
          if (wd[0] && m_busy(cyc)) begin
            for (int k = cyc + 1; k <= bend; k++) sched.delete(k);
            bend = cyc;
          end
          if (wd[1]) begin
            clear_cyc = cyc;
            m_drop    = 0;
          end
        end
        default: ;
      endcase
    end else if (rd) begin
      m_read(off, hit, rdv);
      pend_v    = hit;
      pend_tid  = tid;
      pend_data = rdv;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0, 64'd0, 9'd0);
  endtask

  task automatic wr_reg(input logic [15:0] off, input logic [63:0] wd);
    step(1'b1, 1'b0, off, wd, 9'd0);
  endtask

  task automatic rd_reg(input logic [15:0] off, input logic [8:0] tid,
                        output logic v, output logic [63:0] d);
    step(1'b0, 1'b1, off, 64'd0, tid);
    idle(1);
    v = rsp_seen;
    d = rsp_data;
  endtask

  task automatic set_vec(input int i, input logic wr, input logic [15:0] off, input logic [63:0] wd,
                         input logic [8:0] tid, input logic ev, input logic [63:0] ed);
    tbl[i].wr = wr; tbl[i].off = off; tbl[i].wd = wd;
    tbl[i].tid = tid; tbl[i].exp_v = ev; tbl[i].exp_d = ed;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic        v;
    logic [63:0] d;
    logic [15:0] roffs [14];
    cyc = 0; bstart = 0; bend = 0; clear_cyc = 0; m_drop = 0; busy_cyc = 0;
    m_seed = '0; m_cnt = '0; pend_v = 1'b0; pend_tid = '0; pend_data = '0;
    rsp_seen = 1'b0; rsp_data = '0;
    roffs = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd10, 16'd1, 16'd3, 16'd5,
              16'd7, 16'd9, 16'd11, 16'd12, 16'h0040, 16'hFFFE};

    set_vec(0, 1'b0, 16'd6,   64'd0, 9'h15, 1'b1, 64'd0);
    set_vec(1, 1'b0, 16'd2,   64'd0, 9'h01, 1'b1, 64'd0);
    set_vec(2, 1'b1, 16'd2,   64'h0123_4567_89AB_CDEF, 9'd0, 1'b0, 64'd0);
    set_vec(3, 1'b0, 16'd2,   64'd0, 9'h1FF, 1'b1, 64'h0123_4567_89AB_CDEF);
    set_vec(4, 1'b1, 16'd4,   64'hFFFF_0000_0000_0000, 9'd0, 1'b0, 64'd0);
    set_vec(5, 1'b0, 16'd4,   64'd0, 9'h0A5, 1'b1, 64'd0);
    set_vec(6, 1'b0, 16'h0040, 64'd0, 9'h002, 1'b0, 64'd0);
    set_vec(7, 1'b0, 16'd1,   64'd0, 9'h003, 1'b0, 64'd0);
    set_vec(8, 1'b0, 16'd10,  64'd0, 9'h004, CSUM_ON, 64'd0);
    set_vec(9, 1'b0, 16'd6,   64'd0, 9'h005, 1'b1, 64'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 1;

    // Register table, starting from reset state; CMD=0 must not start a burst.
    obs.delete();
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) begin
        wr_reg(tbl[i].off, tbl[i].wd);
        idle(1);
      end else begin
        rd_reg(tbl[i].off, tbl[i].tid, v, d);
        chk($sformatf("tbl%0d_valid", i), v, tbl[i].exp_v);
        if (tbl[i].exp_v) chk($sformatf("tbl%0d_data", i), d, tbl[i].exp_d);
      end
    end
    chk("cmd0_shifts", obs.size(), 0);

    // Priming: eight pushes fill the FIFO, a ninth keeps fill_lvl saturated.
    for (int i = 1; i <= 8; i++) wr_reg(16'd0, 64'(i));
    idle(1);
    rd_reg(16'd0, 9'h010, v, d);
    chk("head_after_8", d, 64'd1);
    rd_reg(16'd6, 9'h011, v, d);
    chk("status_primed", d, 64'h0000_0000_0008_0002);
    wr_reg(16'd0, 64'd9);
    idle(1);
    rd_reg(16'd6, 9'h012, v, d);
    chk("status_sat", d, 64'h0000_0000_0008_0002);
    rd_reg(16'd0, 9'h013, v, d);
    chk("head_after_9", d, 64'd2);

    // Burst across the 64-bit wrap.
    wr_reg(16'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    obs.delete();
    busy_cyc = 0;
    wr_reg(16'd4, 64'd4);
    idle(6);
    chk("wrap_count", obs.size(), 4);
    if (obs.size() == 4) begin
      chk("wrap_d0", obs[0], 64'hFFFF_FFFF_FFFF_FFFE);
      chk("wrap_d1", obs[1], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("wrap_d2", obs[2], 64'd0);
      chk("wrap_d3", obs[3], 64'd1);
    end
    chk("wrap_busy_cycles", busy_cyc, 4);

    // Long burst with a dropped push at burst cycle 3.
    wr_reg(16'd8, 64'd2);
    obs.delete();
    wr_reg(16'd4, 64'd100);
    idle(3);
    wr_reg(16'd0, 64'hDEAD_BEEF);
    idle(100);
    chk("burst100_shifts", obs.size(), 100);
    rd_reg(16'd6, 9'h020, v, d);
    chk("drop_cnt", d[63:48], 64'd1);

    // Abort at burst cycle 10 leaves exactly 11 shifts.
    obs.delete();
    wr_reg(16'd4, 64'd100);
    idle(10);
    wr_reg(16'd8, 64'd1);
    idle(5);
    chk("abort_shifts", obs.size(), 11);
    chk("abort_idle", busy, 1'b0);
    wr_reg(16'd8, 64'd1);
    idle(2);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      int          r;
      logic [63:0] wd;
      r  = $urandom_range(0, 99);
      wd = {$urandom, $urandom};
      if (r < 35) idle(1);
      else if (r < 55) wr_reg(16'd0, wd);
      else if (r < 62) wr_reg(16'd2, ($urandom_range(0, 1) == 1) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15))) : wd);
      else if (r < 72) wr_reg(16'd4, {wd[63:16], 16'($urandom_range(0, 12))});
      else if (r < 78) wr_reg(16'd8, {62'd0, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1))});
      else if (r < 80) step(1'b1, 1'b1, 16'(2 * $urandom_range(0, 2)), wd, 9'($urandom));
      else step(1'b0, 1'b1, roffs[$urandom_range(0, 13)], 64'd0, 9'($urandom));
    end
    idle(20);

    // Reset in the middle of a burst.
    wr_reg(16'd2, 64'h0000_0000_1000_0000);
    wr_reg(16'd4, 64'd20);
    idle(5);
    chk("pre_reset_en", fifo_en, 1'b1);
    rst_n         = 1'b0;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    #1;
    chk("reset_fifo_en", fifo_en, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rsp_valid", rd_rsp_valid, 1'b0);
    for (int k = cyc; k <= bend; k++) if (sched.exists(k)) sched.delete(k);
    bstart = 0; bend = 0; clear_cyc = cyc; m_drop = 0;
    m_seed = '0; m_cnt = '0; pend_v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
    idle(3);
    rd_reg(16'd6, 9'h030, v, d);
    chk("post_reset_status", d, 64'd0);
    rd_reg(16'd2, 9'h031, v, d);
    chk("post_reset_seed", d, 64'd0);
    idle(25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
